// File: rtl/i2c_pkg.sv
// Shared widths, command word layout and FSM encoding for the I2C command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int CMD_W      = 1 + I2C_ADDR_W + I2C_DATA_W;

  // Command word as stored in the queue: {rw, addr, data}, 16 bits.
  typedef struct packed {
    logic                  rw;
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous DEPTH x cmd_t command queue with count/full/empty.
// Latency: head visible combinationally one cycle after the push into an empty queue.
// Backpressure: pushes while full and pops while empty are ignored.
module i2c_cmd_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  cmd_t                     wr_dat,
  input  logic                     rd_en,
  output cmd_t                     rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = wr_en && !full;
  assign do_pop  = rd_en && !empty;
  assign rd_dat  = mem[rd_ptr];

  // Storage array; no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C commands and launches them one at a time to the master, returning one response each.
// Latency: send 2 clk after a push into an empty idle block; response 1 clk after tx_done rises.
// Backpressure: cmd_ready low while the queue is full; responses have none. Option: I2C_SEQ_TIMEOUT_EN adds a WAIT watchdog.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rw,
  input  logic [I2C_ADDR_W-1:0]  cmd_addr,
  input  logic [I2C_DATA_W-1:0]  cmd_data,
  output logic                   send,
  output logic                   r_w,
  output logic [I2C_ADDR_W-1:0]  master_address,
  output logic [I2C_DATA_W-1:0]  data_in_1,
  input  logic                   tx_done,
  input  logic [I2C_DATA_W-1:0]  data_out_master,
  output logic                   rsp_valid,
  output logic                   rsp_rw,
  output logic [I2C_DATA_W-1:0]  rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t           state;
  cmd_t             cmd_in;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             tx_done_q;
  logic             tx_rise;
  logic [GAP_W-1:0] gap_cnt;

  assign cmd_in    = {cmd_rw, cmd_addr, cmd_data};
  assign cmd_ready = !fifo_full;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  // A level that is already high on WAIT entry has tx_done_q set, so it never counts.
  assign tx_rise   = tx_done && !tx_done_q;

  i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (cmd_valid),
    .wr_dat (cmd_in),
    .rd_en  (pop),
    .rd_dat (head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Launch/complete FSM with registered master-side and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      send           <= 1'b0;
      r_w            <= 1'b0;
      master_address <= '0;
      data_in_1      <= '0;
      rsp_valid      <= 1'b0;
      rsp_rw         <= 1'b0;
      rsp_data       <= '0;
      tx_done_q      <= 1'b0;
      gap_cnt        <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      wait_cnt       <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      tx_done_q <= tx_done;
      send      <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            r_w            <= head.rw;
            master_address <= head.addr;
            data_in_1      <= head.data;
            send           <= 1'b1;
            state          <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state <= ST_WAIT;
`ifdef I2C_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (tx_rise) begin
            rsp_valid <= 1'b1;
            rsp_rw    <= r_w;
            rsp_data  <= r_w ? data_out_master : '0;
            gap_cnt   <= '0;
            state     <= ST_GAP;
`ifdef I2C_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid <= 1'b1;
            rsp_rw    <= r_w;
            rsp_data  <= '0;
            err_q     <= 1'b1;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
`endif
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed self-checking bench for i2c_cmd_sequencer (DEPTH=4, GAP_CYCLES=8, TIMEOUT_CYCLES=16).
// Inputs driven and outputs sampled 1 time unit after the rising edge; responses captured on the falling edge.
// Build with or without +define+I2C_SEQ_TIMEOUT_EN; the timeout test adapts.
module tb_i2c_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int GAP   = 8;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       send;
  logic       r_w;
  logic [6:0] master_address;
  logic [7:0] data_in_1;
  logic       tx_done = 1'b0;
  logic [7:0] data_out_master = '0;
  logic       rsp_valid;
  logic       rsp_rw;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic [2:0] fifo_count;

  i2c_cmd_sequencer #(
    .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .send(send), .r_w(r_w), .master_address(master_address), .data_in_1(data_in_1),
    .tx_done(tx_done), .data_out_master(data_out_master),
    .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int send_cnt = 0;

  typedef struct {
    int         cyc;
    logic       rw;
    logic [7:0] data;
    logic       err;
  } rsp_rec_t;
  rsp_rec_t rsp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Capture every send and response pulse; the two must never coincide.
  always @(negedge clk) begin
    if (send) send_cnt <= send_cnt + 1;
    if (rsp_valid) rsp_q.push_back('{cyc: cyc, rw: rsp_rw, data: rsp_data, err: rsp_err});
    if (send || rsp_valid) check("send_rsp_excl", {31'd0, send & rsp_valid}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command and hold it until accepted; pc is the cycle it was presented.
  task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d, output int pc);
    int n = 0;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    check("push_ready", {31'd0, cmd_ready}, 32'd1);
    pc = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  int         s_cyc;
  logic       s_rw;
  logic [6:0] s_addr;
  logic [7:0] s_data;

  task automatic wait_send(input string tag);
    int n = 0;
    while (!send && n < 200) begin tick(); n++; end
    check({tag, "_send_seen"}, {31'd0, send}, 32'd1);
    s_cyc = cyc; s_rw = r_w; s_addr = master_address; s_data = data_in_1;
  endtask

  task automatic pulse_done(input logic [7:0] d, output int dc);
    data_out_master = d;
    tx_done = 1'b1;
    dc = cyc;
    tick(); tick();
    tx_done = 1'b0;
    tick();
  endtask

  task automatic wait_rsp(input string tag, input int n0);
    int n = 0;
    while (rsp_q.size() <= n0 && n < 100) begin tick(); n++; end
    check({tag, "_rsp_seen"}, {31'd0, rsp_q.size() > n0}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pc, dc, n0, s0;
    rsp_rec_t r;

    // Reset state
    #12;
    check("rst_send", {31'd0, send}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // 1. Write
    push(1'b0, 7'h50, 8'hA5, pc);
    wait_send("wr");
    check("wr_launch_lat", s_cyc - pc, 32'd2);
    check("wr_rw", {31'd0, s_rw}, 32'd0);
    check("wr_addr", {25'd0, s_addr}, 32'h50);
    check("wr_data", {24'd0, s_data}, 32'hA5);
    tick(); tick();
    n0 = rsp_q.size();
    pulse_done(8'hEE, dc);
    wait_rsp("wr", n0);
    r = rsp_q[rsp_q.size()-1];
    check("wr_rsp_lat", r.cyc - dc, 32'd1);
    check("wr_rsp_rw", {31'd0, r.rw}, 32'd0);
    check("wr_rsp_data", {24'd0, r.data}, 32'h00);
    check("wr_rsp_err", {31'd0, r.err}, 32'd0);
    wait_idle("wr");

    // 2. Read
    push(1'b1, 7'h3C, 8'h11, pc);
    wait_send("rd");
    check("rd_rw", {31'd0, s_rw}, 32'd1);
    check("rd_addr", {25'd0, s_addr}, 32'h3C);
    tick();
    n0 = rsp_q.size();
    pulse_done(8'h7E, dc);
    wait_rsp("rd", n0);
    r = rsp_q[rsp_q.size()-1];
    check("rd_rsp_rw", {31'd0, r.rw}, 32'd1);
    check("rd_rsp_data", {24'd0, r.data}, 32'h7E);
    wait_idle("rd");

    // 3. Full FIFO while stalled in WAIT, then in-order drain with gaps
    push(1'b0, 7'h01, 8'h00, pc);
    wait_send("full_x");
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      cmd_valid = 1'b1; cmd_rw = i[0]; cmd_addr = 7'(8'h10 + i); cmd_data = 8'(8'h30 + i);
      tick();
    end
    cmd_rw = 1'b0; cmd_addr = 7'h7F; cmd_data = 8'hFF;
    check("full_count", {29'd0, fifo_count}, 32'd4);
    check("full_ready", {31'd0, cmd_ready}, 32'd0);
    tick(); tick(); tick();
    check("full_hold_count", {29'd0, fifo_count}, 32'd4);
    cmd_valid = 1'b0;
    pulse_done(8'h00, dc);
    for (int i = 0; i < DEPTH; i++) begin
      wait_send("drain");
      check("drain_addr", {25'd0, s_addr}, 32'h10 + i);
      check("drain_data", {24'd0, s_data}, 32'h30 + i);
      check("drain_rw", {31'd0, s_rw}, i & 1);
      check("drain_count", {29'd0, fifo_count}, 3 - i);
      check("drain_gap", {31'd0, (s_cyc - dc) >= GAP}, 32'd1);
      tick();
      n0 = rsp_q.size();
      pulse_done(8'(8'h60 + i), dc);
      wait_rsp("drain", n0);
      r = rsp_q[rsp_q.size()-1];
      check("drain_rsp_data", {24'd0, r.data}, (i & 1) ? 32'h60 + i : 32'h0);
    end
    wait_idle("drain");

    // 4. tx_done held high from before LAUNCH
    tx_done = 1'b1;
    tick();
    push(1'b1, 7'h21, 8'h00, pc);
    wait_send("held");
    n0 = rsp_q.size();
    for (int i = 0; i < 6; i++) tick();
    check("held_no_rsp", rsp_q.size(), n0);
    tx_done = 1'b0;
    tick();
    pulse_done(8'h42, dc);
    wait_rsp("held", n0);
    r = rsp_q[rsp_q.size()-1];
    check("held_rsp_data", {24'd0, r.data}, 32'h42);
    wait_idle("held");

    // 5. Watchdog
    push(1'b1, 7'h2A, 8'h00, pc);
    push(1'b0, 7'h2B, 8'h5A, pc);
    wait_send("tmo");
    s0 = s_cyc;
    n0 = rsp_q.size();
`ifdef I2C_SEQ_TIMEOUT_EN
    wait_rsp("tmo", n0);
    r = rsp_q[rsp_q.size()-1];
    check("tmo_err", {31'd0, r.err}, 32'd1);
    check("tmo_data", {24'd0, r.data}, 32'h00);
    check("tmo_lat", r.cyc - s0, TMO + 1);
    wait_send("tmo_next");
    check("tmo_next_addr", {25'd0, s_addr}, 32'h2B);
    tick();
    push(1'b0, 7'h31, 8'h01, pc);
    push(1'b0, 7'h32, 8'h02, pc);
`else
    for (int i = 0; i < 40; i++) tick();
    check("notmo_busy", {31'd0, busy}, 32'd1);
    check("notmo_no_rsp", rsp_q.size(), n0);
    push(1'b0, 7'h31, 8'h01, pc);
`endif
    check("pre_rst_count", {29'd0, fifo_count}, 32'd2);

    // 6. Reset mid-WAIT with two queued commands
    rst = 1'b0;
    #1;
    check("mid_rst_send", {31'd0, send}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    tick(); tick();
    rst = 1'b1;
    n0 = rsp_q.size();
    s0 = send_cnt;
    tick(); tick(); tick();
    pulse_done(8'h99, dc);
    for (int i = 0; i < 30; i++) tick();
    check("post_rst_no_rsp", rsp_q.size(), n0);
    check("post_rst_no_send", send_cnt, s0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
